// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART transmit path.
// Holds the serializer state encoding, frame-length constants and the
// even-parity helper used when a byte is accepted.
package uart_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_IDX_W = 3;

    // Bit periods per frame: start + 8 data + [parity] + stop
    localparam int unsigned FRAME_BITS_PAR   = 11;
    localparam int unsigned FRAME_BITS_NOPAR = 10;

    // Serializer states (plain constants so legacy tools can consume them)
    localparam logic [STATE_W-1:0] ST_IDLE       = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_ALIGN = 3'd1;
    localparam logic [STATE_W-1:0] ST_START      = 3'd2;
    localparam logic [STATE_W-1:0] ST_DATA       = 3'd3;
    localparam logic [STATE_W-1:0] ST_PARITY     = 3'd4;
    localparam logic [STATE_W-1:0] ST_STOP       = 3'd5;

    localparam logic [BIT_IDX_W-1:0] LAST_BIT_IDX = BIT_IDX_W'(DATA_BITS - 1);

    // Even parity bit: makes the total count of ones (data + parity) even
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: frames a byte as start/8 data (LSB first)/[even parity]/stop
// and shifts it onto TxD, one bit per Tx_sample_ENABLE pulse.
// Ports:
//   Clk              - system clock
//   reset            - asynchronous active-low reset
//   Tx_sample_ENABLE - one-cycle pulse per bit period from the baud generator
//   Tx_EN            - transmitter enable, gates acceptance of new frames
//   Tx_WR            - one-cycle write strobe for Tx_DATA
//   Tx_DATA          - byte to transmit
//   TxD              - serial line, idle high (registered)
//   Tx_BUSY          - high from accept until end of stop bit (registered)
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter logic PARITY_EN = 1'b1
) (
    input  logic                 Clk,
    input  logic                 reset,
    input  logic                 Tx_sample_ENABLE,
    input  logic                 Tx_EN,
    input  logic                 Tx_WR,
    input  logic [DATA_BITS-1:0] Tx_DATA,
    output logic                 TxD,
    output logic                 Tx_BUSY
);

    logic [STATE_W-1:0]   state_q,   state_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] data_q,    data_d;
    logic                 parity_q,  parity_d;
    logic                 txd_q,     txd_d;
    logic                 busy_q,    busy_d;

    // State and datapath registers
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and next-output logic. TxD is computed one step ahead so that
    // the registered line changes only in the cycle following a sample pulse.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        parity_d  = parity_q;
        txd_d     = txd_q;
        busy_d    = busy_q;

        case (state_q)
            ST_IDLE: begin
                // Sample pulses here are ignored; a coincident pulse therefore
                // cannot start the frame, the wait-for-alignment state absorbs it.
                if (Tx_WR && Tx_EN) begin
                    data_d    = Tx_DATA;
                    parity_d  = even_parity(Tx_DATA);
                    bit_idx_d = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_WAIT_ALIGN;
                end
            end
            ST_WAIT_ALIGN: begin
                if (Tx_sample_ENABLE) begin
                    txd_d   = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (Tx_sample_ENABLE) begin
                    txd_d     = data_q[0];
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (Tx_sample_ENABLE) begin
                    if (bit_idx_q == LAST_BIT_IDX) begin
                        // Leave DATA instead of wrapping into a ninth bit
                        bit_idx_d = '0;
                        if (PARITY_EN) begin
                            txd_d   = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = ST_STOP;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = data_q[bit_idx_q + 3'd1];
                    end
                end
            end
            ST_PARITY: begin
                if (Tx_sample_ENABLE) begin
                    txd_d   = 1'b1;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Busy drops as the stop period ends, so a write in that very
                // cycle is seen in IDLE and accepted back-to-back.
                if (Tx_sample_ENABLE) begin
                    txd_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                txd_d     = 1'b1;
                busy_d    = 1'b0;
                bit_idx_d = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    assign TxD     = txd_q;
    assign Tx_BUSY = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed, table-driven bench for uart_tx_serializer.
// Two instances (with and without parity) share clock, reset, sample pulse,
// enable and data; each has its own write strobe.
module tb_uart_tx_serializer;
    import uart_pkg::*;

    localparam int BIT = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pulse;
    logic       en;
    logic       wr_p, wr_n;
    logic [7:0] data;
    logic       txd_p, busy_p, txd_n, busy_n;

    int errors = 0;
    int checks = 0;
    int cnt    = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.PARITY_EN(1'b1)) dut_p (
        .Clk(clk), .reset(rst_n), .Tx_sample_ENABLE(pulse), .Tx_EN(en),
        .Tx_WR(wr_p), .Tx_DATA(data), .TxD(txd_p), .Tx_BUSY(busy_p)
    );

    uart_tx_serializer #(.PARITY_EN(1'b0)) dut_n (
        .Clk(clk), .reset(rst_n), .Tx_sample_ENABLE(pulse), .Tx_EN(en),
        .Tx_WR(wr_n), .Tx_DATA(data), .TxD(txd_n), .Tx_BUSY(busy_n)
    );

    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic [10:0] exp;    // bit i = line level in bit period i
        int          nb;
        int          drop_at;
        int          inj_at;
        string       name;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance to the next falling edge and set the pulse seen at the next rising edge
    task automatic tick();
        @(negedge clk);
        pulse = (cnt == BIT - 1);
        cnt   = (cnt == BIT - 1) ? 0 : cnt + 1;
    endtask

    function automatic logic txd_of(input logic pe);
        return pe ? txd_p : txd_n;
    endfunction

    function automatic logic busy_of(input logic pe);
        return pe ? busy_p : busy_n;
    endfunction

    task automatic send(input logic pe, input logic [7:0] d, input string name);
        data = d;
        if (pe) wr_p = 1'b1; else wr_n = 1'b1;
        tick();
        wr_p = 1'b0;
        wr_n = 1'b0;
        chk({name, " busy_after_accept"}, 32'(busy_of(pe)), 32'd1);
    endtask

    task automatic capture(input logic pe, input logic [10:0] exp, input int nb,
                           input int drop_at, input int inj_at, input string name,
                           output int lat);
        int          i       = 0;
        int          budget  = 0;
        logic [10:0] got     = '0;
        logic        busy_ok = 1'b1;
        lat = 0;
        while (txd_of(pe) !== 1'b0 && lat < 3 * BIT) begin
            if (busy_of(pe) !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
        chk({name, " start_latency_in_range"}, 32'(lat >= 1 && lat <= BIT + 1), 32'd1);
        while (i < nb && budget < 12 * (BIT + 1)) begin
            if (busy_of(pe) !== 1'b1) busy_ok = 1'b0;
            if (pulse) begin
                got[i] = txd_of(pe);
                if (i == drop_at) en = 1'b0;
                if (i == inj_at) begin
                    data = 8'h3C;
                    if (pe) wr_p = 1'b1; else wr_n = 1'b1;
                end
                i++;
            end
            tick();
            wr_p = 1'b0;
            wr_n = 1'b0;
            budget++;
        end
        chk({name, " frame_bits"}, 32'(got), 32'(exp));
        chk({name, " busy_through_frame"}, 32'(busy_ok), 32'd1);
        chk({name, " idle_after_stop"}, {30'd0, busy_of(pe), txd_of(pe)}, 32'd1);
        en = 1'b1;
    endtask

    task automatic watch_idle(input logic pe, input int n, input string name);
        logic ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            if (busy_of(pe) !== 1'b0 || txd_of(pe) !== 1'b1) ok = 1'b0;
            tick();
        end
        chk({name, " line_stays_idle"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int guard;

        vecs[0] = '{8'hA5, 1'b1, 11'b10101001010, FRAME_BITS_PAR,   -1, -1, "a5_par"};
        vecs[1] = '{8'h07, 1'b1, 11'b11000001110, FRAME_BITS_PAR,   -1, -1, "07_par"};
        vecs[2] = '{8'h07, 1'b0, 11'b01000001110, FRAME_BITS_NOPAR, -1, -1, "07_nopar"};
        vecs[3] = '{8'hA5, 1'b1, 11'b10101001010, FRAME_BITS_PAR,   -1,  3, "a5_wr_midframe"};
        vecs[4] = '{8'h55, 1'b1, 11'b10010101010, FRAME_BITS_PAR,    4, -1, "55_en_drop"};
        vecs[5] = '{8'h80, 1'b0, 11'b01100000000, FRAME_BITS_NOPAR, -1, -1, "80_nopar"};

        rst_n = 1'b1; pulse = 1'b0; en = 1'b1; wr_p = 1'b0; wr_n = 1'b0; data = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        chk("reset txd_p", 32'(txd_p), 32'd1);
        chk("reset busy_p", 32'(busy_p), 32'd0);
        chk("reset txd_n", 32'(txd_n), 32'd1);
        chk("reset busy_n", 32'(busy_n), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        watch_idle(1'b1, 2 * BIT, "pulses_in_idle");

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].pe, vecs[v].d, vecs[v].name);
            capture(vecs[v].pe, vecs[v].exp, vecs[v].nb, vecs[v].drop_at,
                    vecs[v].inj_at, vecs[v].name, lat);
            watch_idle(vecs[v].pe, 2 * BIT, {vecs[v].name, " no_extra_frame"});
        end

        // Write with transmitter disabled is ignored
        en = 1'b0;
        data = 8'h12;
        wr_p = 1'b1;
        tick();
        wr_p = 1'b0;
        watch_idle(1'b1, 2 * BIT, "wr_with_en_low");
        en = 1'b1;

        // Sample pulse coincident with the accepting write does not start the frame
        guard = 0;
        while (pulse !== 1'b1 && guard < 2 * BIT) begin tick(); guard++; end
        send(1'b1, 8'hA5, "coincident");
        capture(1'b1, 11'b10101001010, FRAME_BITS_PAR, -1, -1, "coincident", lat);
        chk("coincident start_latency_full_period", 32'(lat), 32'(BIT));
        watch_idle(1'b1, BIT, "coincident after");

        // Back-to-back: write in the cycle busy falls
        send(1'b1, 8'h07, "b2b_first");
        capture(1'b1, 11'b11000001110, FRAME_BITS_PAR, -1, -1, "b2b_first", lat);
        send(1'b1, 8'hFF, "b2b_second");
        capture(1'b1, 11'b10111111110, FRAME_BITS_PAR, -1, -1, "b2b_second", lat);
        watch_idle(1'b1, BIT, "b2b after");

        // Reset during data bit 4 aborts the frame
        send(1'b1, 8'hA5, "reset_mid");
        guard = 0;
        while (txd_p !== 1'b0 && guard < 3 * BIT) begin tick(); guard++; end
        n = 0;
        guard = 0;
        while (n < 5 && guard < 8 * BIT) begin
            if (pulse) n++;
            tick();
            guard++;
        end
        tick(); tick();
        chk("reset_mid txd_before_reset_is_bit4", 32'(txd_p), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_mid txd_immediate", 32'(txd_p), 32'd1);
        chk("reset_mid busy_immediate", 32'(busy_p), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        watch_idle(1'b1, 3 * BIT, "after_reset_release");
        send(1'b1, 8'h55, "post_reset_55");
        capture(1'b1, 11'b10010101010, FRAME_BITS_PAR, -1, -1, "post_reset_55", lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
